// File: rtl/lock_pkg.sv
// Shared types and key codes for the keypad lock controller.
package lock_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ENTRY   = 3'd1,
    OPEN    = 3'd2,
    LOCKOUT = 3'd3,
    ALARM   = 3'd4
  } ctrl_state_t;

  localparam logic [4:0] KEY_ENTER = 5'd16;
  localparam logic [4:0] KEY_CLEAR = 5'd17;
  localparam logic [4:0] KEY_LOCK  = 5'd18;

endpackage

// File: rtl/lock_sequencer_sec_timer.sv
// Seconds down-counter with a CLK_HZ prescaler; expire fires on the cycle whose edge reaches 0.
module sec_timer #(
  parameter int unsigned CLK_HZ = 100
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic [7:0] load_val,
  output logic [7:0] secs_left,
  output logic       expire
);

  localparam int unsigned PW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [PW-1:0] PreMax = PW'(CLK_HZ - 1);

  logic [PW-1:0] presc_q, presc_d;
  logic [7:0]    secs_q, secs_d;
  logic          wrap;

  assign wrap = (presc_q == PreMax);

  always_comb begin
    presc_d = presc_q;
    secs_d  = secs_q;
    if (load) begin
      presc_d = '0;
      secs_d  = load_val;
    end else if (secs_q != 8'd0) begin
      if (wrap) begin
        presc_d = '0;
        secs_d  = secs_q - 8'd1;
      end else begin
        presc_d = presc_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_q <= '0;
      secs_q  <= '0;
    end else begin
      presc_q <= presc_d;
      secs_q  <= secs_d;
    end
  end

  // Combinational so the FSM transitions on the very edge the count hits zero.
  assign expire    = wrap && (secs_q == 8'd1);
  assign secs_left = secs_q;

endmodule

// File: rtl/lock_sequencer.sv
// Keypad lock: code entry, attempt limiting, timed lockout and sticky alarm.
module lock_sequencer
  import lock_pkg::*;
#(
  parameter int unsigned CLK_HZ    = 100,
  parameter int unsigned DIGITS    = 8,
  parameter int unsigned MAX_TRIES = 3,
  parameter int unsigned ENTRY_S   = 5,
  parameter int unsigned LOCKOUT_S = 10,
  parameter int unsigned OPEN_S    = 15
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  key_strobe,
  input  logic [4:0]            key_code,
  input  logic [4*DIGITS-1:0]   code_word,
  input  logic                  code_valid,
  output ctrl_state_t           state,
  output logic [3:0]            digit_idx,
  output logic [1:0]            tries_left,
  output logic [7:0]            secs_left,
  output logic                  unlocked,
  output logic                  lockout,
  output logic                  alarm,
  output logic                  fail_pulse
);

  localparam logic [7:0] EntryV   = 8'(ENTRY_S);
  localparam logic [7:0] LockoutV = 8'(LOCKOUT_S);
  localparam logic [7:0] OpenV    = 8'(OPEN_S);
  localparam logic [1:0] MaxV     = 2'(MAX_TRIES);
  localparam logic [3:0] LastIdx  = 4'(DIGITS - 1);

  ctrl_state_t state_q, state_d;
  logic [3:0]  idx_q, idx_d;
  logic        mism_q, mism_d, mism_nx;
  logic [1:0]  tries_q, tries_d, tries_nx;
  logic        lcnt_q, lcnt_d;
  logic        fail_q, fail_d;
  logic        strobe_q, key_evt_q;
  logic [4:0]  key_q;
  logic        tmr_load, expire, do_fail;
  logic [7:0]  tmr_val;
  logic [3:0]  nib;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      strobe_q  <= 1'b0;
      key_evt_q <= 1'b0;
      key_q     <= '0;
    end else begin
      strobe_q  <= key_strobe;
      key_evt_q <= key_strobe & ~strobe_q;
      if (key_strobe & ~strobe_q) key_q <= key_code;
    end
  end

  // Digit 0 is the most significant nibble.
  always_comb begin
    nib = '0;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (idx_q == 4'(i)) nib = code_word[(DIGITS-1-i)*4 +: 4];
    end
  end

  sec_timer #(
    .CLK_HZ(CLK_HZ)
  ) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (tmr_load),
    .load_val (tmr_val),
    .secs_left(secs_left),
    .expire   (expire)
  );

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    mism_d   = mism_q;
    tries_d  = tries_q;
    tries_nx = tries_q;
    lcnt_d   = lcnt_q;
    fail_d   = 1'b0;
    tmr_load = 1'b0;
    tmr_val  = '0;
    do_fail  = 1'b0;
    mism_nx  = mism_q | (key_q[3:0] != nib);

    unique case (state_q)
      IDLE: begin
        if (key_evt_q && key_q == KEY_ENTER && code_valid) begin
          state_d  = ENTRY;
          idx_d    = '0;
          mism_d   = 1'b0;
          tmr_load = 1'b1;
          tmr_val  = EntryV;
        end
      end
      ENTRY: begin
        if (key_evt_q && !key_q[4]) begin
          idx_d    = idx_q + 4'd1;
          mism_d   = mism_nx;
          tmr_load = 1'b1;
          tmr_val  = EntryV;
          if (idx_q == LastIdx) begin
            if (!mism_nx) begin
              state_d = OPEN;
              tries_d = MaxV;
              lcnt_d  = 1'b0;
              tmr_val = OpenV;
            end else begin
              do_fail = 1'b1;
            end
          end
        end else if (key_evt_q && (key_q == KEY_ENTER || key_q == KEY_CLEAR)) begin
          idx_d    = '0;
          mism_d   = 1'b0;
          tmr_load = 1'b1;
          tmr_val  = EntryV;
        end else if (expire) begin
          do_fail = 1'b1;
        end
      end
      OPEN: begin
        if (key_evt_q && key_q == KEY_ENTER) begin
          state_d  = ENTRY;
          idx_d    = '0;
          mism_d   = 1'b0;
          tmr_load = 1'b1;
          tmr_val  = EntryV;
        end else if ((key_evt_q && key_q == KEY_LOCK) || expire) begin
          state_d = IDLE;
          idx_d   = '0;
        end
      end
      LOCKOUT: begin
        if (expire) begin
          state_d = IDLE;
          tries_d = MaxV;
        end
      end
      ALARM: ;
      default: state_d = IDLE;
    endcase

    if (do_fail) begin
      fail_d   = 1'b1;
      tries_nx = (tries_q == 2'd0) ? 2'd0 : tries_q - 2'd1;
      tries_d  = tries_nx;
      idx_d    = '0;
      mism_d   = 1'b0;
      if (tries_nx != 2'd0) begin
        state_d = IDLE;
      end else if (lcnt_q) begin
        state_d = ALARM;
      end else begin
        state_d  = LOCKOUT;
        lcnt_d   = 1'b1;
        tmr_load = 1'b1;
        tmr_val  = LockoutV;
      end
    end

    // Losing the programmed code aborts everything except a raised alarm, without penalty.
    if (!code_valid && state_q != ALARM) begin
      state_d = IDLE;
      idx_d   = '0;
      mism_d  = 1'b0;
      tries_d = tries_q;
      lcnt_d  = lcnt_q;
      fail_d  = 1'b0;
    end

    if (state_d == IDLE || state_d == ALARM) begin
      tmr_load = 1'b1;
      tmr_val  = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      mism_q  <= 1'b0;
      tries_q <= MaxV;
      lcnt_q  <= 1'b0;
      fail_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      mism_q  <= mism_d;
      tries_q <= tries_d;
      lcnt_q  <= lcnt_d;
      fail_q  <= fail_d;
    end
  end

  assign state      = state_q;
  assign digit_idx  = idx_q;
  assign tries_left = tries_q;
  assign unlocked   = (state_q == OPEN);
  assign lockout    = (state_q == LOCKOUT);
  assign alarm      = (state_q == ALARM);
  assign fail_pulse = fail_q;

endmodule

// File: tb/tb_lock_sequencer.sv
// Scoreboard bench for lock_sequencer: expected state-change events are queued by the stimulus.
module tb_lock_sequencer;
  import lock_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        key_strobe = 1'b0;
  logic [4:0]  key_code = '0;
  logic [31:0] code_word = 32'h1234_5678;
  logic        code_valid = 1'b1;
  ctrl_state_t state;
  logic [3:0]  digit_idx;
  logic [1:0]  tries_left;
  logic [7:0]  secs_left;
  logic        unlocked, lockout, alarm, fail_pulse;

  lock_sequencer dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .key_strobe(key_strobe),
    .key_code  (key_code),
    .code_word (code_word),
    .code_valid(code_valid),
    .state     (state),
    .digit_idx (digit_idx),
    .tries_left(tries_left),
    .secs_left (secs_left),
    .unlocked  (unlocked),
    .lockout   (lockout),
    .alarm     (alarm),
    .fail_pulse(fail_pulse)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    string name;
    int    st;
    int    tries;
    int    fail;
    int    secs;
    int    at;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   failures = 0;
  bit   mon_en = 1'b0;

  task automatic expect_ev(input string name, input int st, input int tries, input int fail,
                           input int secs, input int at);
    exp_t e;
    e.name = name; e.st = st; e.tries = tries; e.fail = fail; e.secs = secs; e.at = at;
    q.push_back(e);
  endtask

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cyc %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: every state change or fail pulse must match the head of the queue.
  initial begin
    ctrl_state_t prev;
    exp_t e;
    bit ok;
    prev = IDLE;
    forever begin
      @(negedge clk);
      if (mon_en && (state !== prev || fail_pulse === 1'b1)) begin
        checks++;
        if (q.size() == 0) begin
          failures++;
          $display("FAIL unexpected_event: state=%0d tries=%0d fail=%0d cyc=%0d",
                   state, tries_left, fail_pulse, cyc);
        end else begin
          e = q.pop_front();
          ok = (int'(state) == e.st) && (int'(tries_left) == e.tries) &&
               (int'(fail_pulse) == e.fail) && (e.secs < 0 || int'(secs_left) == e.secs) &&
               (e.at < 0 || cyc == e.at) && (unlocked == (e.st == int'(OPEN))) &&
               (lockout == (e.st == int'(LOCKOUT))) && (alarm == (e.st == int'(ALARM)));
          if (!ok) begin
            failures++;
            $display("FAIL %s: got state=%0d tries=%0d fail=%0d secs=%0d cyc=%0d flags=%b%b%b; expected state=%0d tries=%0d fail=%0d secs=%0d cyc=%0d",
                     e.name, state, tries_left, fail_pulse, secs_left, cyc, unlocked, lockout,
                     alarm, e.st, e.tries, e.fail, e.secs, e.at);
          end
        end
      end
      prev = state;
    end
  end

  task automatic wait_drain(input int budget);
    int n = 0;
    while (q.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (q.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL drain_timeout: %0d events pending, head %s", q.size(), q[0].name);
      q.delete();
    end
  endtask

  // Called right after a negedge; returns cyc at the moment the key goes down.
  task automatic key_down(input logic [4:0] k, output int c);
    c = cyc;
    key_strobe = 1'b1;
    key_code = k;
  endtask

  task automatic key_up(input int hold);
    repeat (hold) @(negedge clk);
    key_strobe = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic tap(input logic [4:0] k);
    int c;
    @(negedge clk);
    key_down(k, c);
    key_up(2);
  endtask

  task automatic tap_exp(input logic [4:0] k, input string name, input int st, input int tries,
                         input int fail, input int secs);
    int c;
    @(negedge clk);
    key_down(k, c);
    expect_ev(name, st, tries, fail, secs, c + 2);
    key_up(2);
  endtask

  task automatic bad_attempt(input int tries_before, input int st, input int tries_after,
                             input int secs);
    tap_exp(KEY_ENTER, "bad_enter", int'(ENTRY), tries_before, 0, 5);
    for (int d = 0; d < 7; d++) tap(5'(d));
    tap_exp(5'd8, "bad_result", st, tries_after, 1, secs);
  endtask

  task automatic good_code(input int tries_before);
    for (int d = 1; d <= 7; d++) tap(5'(d));
    tap_exp(5'd8, "open", int'(OPEN), 3, 0, 15);
  endtask

  task automatic pulse_reset(input string name);
    expect_ev(name, int'(IDLE), 3, 0, 0, -1);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check({name, "_state"}, int'(state), int'(IDLE));
    check({name, "_tries"}, int'(tries_left), 3);
    check({name, "_secs"}, int'(secs_left), 0);
    check({name, "_flags"}, int'({unlocked, lockout, alarm, fail_pulse}), 0);
    @(posedge clk);
    #2 rst_n = 1'b1;
    wait_drain(20);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int c, l, t;
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_state", int'(state), int'(IDLE));
    check("rst_idx", int'(digit_idx), 0);
    check("rst_tries", int'(tries_left), 3);
    check("rst_secs", int'(secs_left), 0);
    check("rst_flags", int'({unlocked, lockout, alarm, fail_pulse}), 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    mon_en = 1'b1;

    // 1: correct code unlocks, then relocks after 15 s
    tap_exp(KEY_ENTER, "t1_enter", int'(ENTRY), 3, 0, 5);
    for (int d = 1; d <= 7; d++) tap(5'(d));
    @(negedge clk);
    key_down(5'd8, c);
    expect_ev("t1_open", int'(OPEN), 3, 0, 15, c + 2);
    expect_ev("t1_relock", int'(IDLE), 3, 0, 0, c + 2 + 1500);
    key_up(2);
    check("t1_idx_open", int'(digit_idx), 8);
    wait_drain(1600);

    // 2: wrong digit stays silent until the last digit
    tap_exp(KEY_ENTER, "t2_enter", int'(ENTRY), 3, 0, 5);
    tap(5'd1); tap(5'd2); tap(5'd9); tap(5'd4); tap(5'd5); tap(5'd6); tap(5'd7);
    check("t2_idx7", int'(digit_idx), 7);
    check("t2_still_entry", int'(state), int'(ENTRY));
    tap_exp(5'd8, "t2_fail", int'(IDLE), 2, 1, 0);
    wait_drain(20);

    // 3: lockout, ignored keys, then alarm on the next round
    bad_attempt(2, int'(IDLE), 1, 0);
    @(negedge clk);
    tap_exp(KEY_ENTER, "t3_enter", int'(ENTRY), 1, 0, 5);
    for (int d = 0; d < 7; d++) tap(5'(d));
    @(negedge clk);
    key_down(5'd8, c);
    expect_ev("t3_lockout", int'(LOCKOUT), 0, 1, 10, c + 2);
    expect_ev("t3_lock_end", int'(IDLE), 3, 0, 0, c + 2 + 1000);
    key_up(2);
    tap(KEY_ENTER); tap(5'd1); tap(KEY_CLEAR);
    check("t3_lockout_hold", int'(state), int'(LOCKOUT));
    wait_drain(1100);
    bad_attempt(3, int'(IDLE), 2, 0);
    bad_attempt(2, int'(IDLE), 1, 0);
    bad_attempt(1, int'(ALARM), 0, 0);
    tap(KEY_ENTER); tap(5'd1);
    repeat (200) @(negedge clk);
    check("t3_alarm_sticky", int'(alarm), 1);
    check("t3_alarm_secs", int'(secs_left), 0);
    pulse_reset("t3_reset");

    // 4: entry timeout, then CLEAR followed by the correct code
    tap_exp(KEY_ENTER, "t4_enter", int'(ENTRY), 3, 0, 5);
    tap(5'd1);
    @(negedge clk);
    key_down(5'd2, c);
    expect_ev("t4_timeout", int'(IDLE), 2, 1, 0, c + 502);
    key_up(2);
    wait_drain(600);
    tap_exp(KEY_ENTER, "t4_enter2", int'(ENTRY), 2, 0, 5);
    tap(5'd1);
    tap(KEY_CLEAR);
    check("t4_clear_idx", int'(digit_idx), 0);
    good_code(2);
    tap_exp(KEY_LOCK, "t4_lock", int'(IDLE), 3, 0, 0);
    wait_drain(20);

    // 5: held key counts once; key on the expiry edge wins
    tap_exp(KEY_ENTER, "t5_enter", int'(ENTRY), 3, 0, 5);
    @(negedge clk);
    key_down(5'd1, c);
    key_up(50);
    check("t5_hold_idx", int'(digit_idx), 1);
    l = c + 2;
    t = l + 498;
    while (cyc < t) @(negedge clk);
    key_down(5'd2, c);
    @(negedge clk);
    @(negedge clk);
    check("t5_race_state", int'(state), int'(ENTRY));
    check("t5_race_idx", int'(digit_idx), 2);
    check("t5_race_secs", int'(secs_left), 5);
    key_strobe = 1'b0;
    repeat (2) @(negedge clk);

    // 6: code_valid drop aborts without penalty; reset mid-lockout
    @(negedge clk);
    expect_ev("t6_cv_drop", int'(IDLE), 3, 0, 0, cyc + 1);
    code_valid = 1'b0;
    repeat (3) @(negedge clk);
    tap(KEY_ENTER);
    check("t6_cv_blocked", int'(state), int'(IDLE));
    code_valid = 1'b1;
    wait_drain(20);
    bad_attempt(3, int'(IDLE), 2, 0);
    bad_attempt(2, int'(IDLE), 1, 0);
    bad_attempt(1, int'(LOCKOUT), 0, 10);
    repeat (300) @(negedge clk);
    pulse_reset("t6_reset");

    wait_drain(50);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
